// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor: counter encodings,
// the sequential-fetch increment and the PC index/tag slicing helpers.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam int unsigned PC_INC   = 4;
    localparam int unsigned PC_W_MAX = 64;

    // Helpers take a zero-extended PC so any W_SIZE up to PC_W_MAX can share them.
    function automatic logic [PC_W_MAX-1:0] pcIndex(input logic [PC_W_MAX-1:0] pc,
                                                    input int unsigned idxBits);
        logic [PC_W_MAX-1:0] mask;
        mask = (PC_W_MAX'(1) << idxBits) - PC_W_MAX'(1);
        return (pc >> 2) & mask;
    endfunction

    function automatic logic [PC_W_MAX-1:0] pcTag(input logic [PC_W_MAX-1:0] pc,
                                                  input int unsigned idxBits);
        return pc >> (idxBits + 2);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] nextCtr
);

    always_comb begin
        nextCtr = ctr;
        if (taken) begin
            if (ctr != ST) nextCtr = ctr + 2'd1;
        end else begin
            if (ctr != SNT) nextCtr = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, trained by execute; also keeps
// saturating branch / mispredict statistics for the CSR path.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int W_SIZE    = 32,
    parameter int N_ENTRIES = 32,
    parameter int IDX_BITS  = $clog2(N_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [W_SIZE-1:0] lookup_pc,
    output logic              pred_taken,
    output logic [W_SIZE-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [W_SIZE-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [W_SIZE-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [W_SIZE-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [31:0]       br_count,
    output logic [31:0]       mispred_count
);

    localparam int TAG_W = W_SIZE - IDX_BITS - 2;

    function automatic logic [31:0] satInc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [N_ENTRIES-1:0] validTbl;
    logic [1:0]           ctrTbl    [N_ENTRIES];
    logic [TAG_W-1:0]     tagTbl    [N_ENTRIES];
    logic [W_SIZE-1:0]    targetTbl [N_ENTRIES];

    logic [31:0] brCount;
    logic [31:0] mispredCount;
    logic        mispredictQ;

    logic [IDX_BITS-1:0] lookupIdx;
    logic [TAG_W-1:0]    lookupTag;
    logic                lookupHit;
    logic [IDX_BITS-1:0] updIdx;
    logic [TAG_W-1:0]    updTag;
    logic                updHit;
    logic [1:0]          updNextCtr;
    logic                mispredCond;

    assign lookupIdx = IDX_BITS'(pcIndex(PC_W_MAX'(lookup_pc), IDX_BITS));
    assign lookupTag = TAG_W'(pcTag(PC_W_MAX'(lookup_pc), IDX_BITS));
    assign updIdx    = IDX_BITS'(pcIndex(PC_W_MAX'(upd_pc), IDX_BITS));
    assign updTag    = TAG_W'(pcTag(PC_W_MAX'(upd_pc), IDX_BITS));

    // Lookup reads registered state only, so a same-cycle update is not visible.
    assign lookupHit   = validTbl[lookupIdx] && (tagTbl[lookupIdx] == lookupTag);
    assign pred_taken  = lookupHit && ctrTbl[lookupIdx][1];
    assign pred_target = pred_taken ? targetTbl[lookupIdx] : lookup_pc + W_SIZE'(PC_INC);

    assign updHit      = validTbl[updIdx] && (tagTbl[updIdx] == updTag);
    assign mispredCond = (upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target));

    sat_counter2 updCtr (
        .ctr     (ctrTbl[updIdx]),
        .taken   (upd_taken),
        .nextCtr (updNextCtr)
    );

    // Control state: valid bits, counters and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validTbl     <= '0;
            for (int i = 0; i < N_ENTRIES; i++) ctrTbl[i] <= WNT;
            mispredictQ  <= 1'b0;
            brCount      <= '0;
            mispredCount <= '0;
        end else begin
            mispredictQ <= upd_valid && mispredCond;
            if (upd_valid) brCount <= satInc32(brCount);
            if (upd_valid && mispredCond) mispredCount <= satInc32(mispredCount);

            if (clear) begin
                validTbl <= '0;
                for (int i = 0; i < N_ENTRIES; i++) ctrTbl[i] <= WNT;
            end else if (upd_valid) begin
                if (updHit) begin
                    ctrTbl[updIdx] <= updNextCtr;
                end else if (upd_taken) begin
                    validTbl[updIdx] <= 1'b1;
                    ctrTbl[updIdx]   <= WT;
                end
            end
        end
    end

    // Tag/target payload is meaningless without its valid bit, so it is not reset.
    always_ff @(posedge clk) begin
        if (rst_n && !clear && upd_valid && upd_taken) begin
            tagTbl[updIdx]    <= updTag;
            targetTbl[updIdx] <= upd_target;
        end
    end

    assign mispredict    = mispredictQ;
    assign br_count      = brCount;
    assign mispred_count = mispredCount;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup, training, aliasing, clear,
// saturation and reset behaviour against hand-computed values.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    branch_predictor #(.W_SIZE(32), .N_ENTRIES(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (clear),
        .lookup_pc       (lookup_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .br_count        (br_count),
        .mispred_count   (mispred_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic pTk, input logic [31:0] pTgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = pTk;
        upd_pred_target = pTgt;
    endtask

    task automatic idle();
        upd_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc, input logic expTk, input logic [31:0] expTgt,
                        input string tag);
        lookup_pc = pc;
        #1;
        chk({tag, "_taken"}, 32'(pred_taken), 32'(expTk));
        chk({tag, "_target"}, pred_target, expTgt);
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        lookup_pc = 32'h0000_1000;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_taken = 1'b0;
        upd_target = '0;
        upd_pred_taken = 1'b0;
        upd_pred_target = '0;

        look(32'h0000_1000, 1'b0, 32'h0000_1004, "in_reset");
        #12 rst_n = 1'b1;
        tick();
        look(32'h0000_1000, 1'b0, 32'h0000_1004, "post_reset");
        chk("reset_br", br_count, 32'd0);
        chk("reset_mis", mispred_count, 32'd0);
        chk("reset_mispredict", 32'(mispredict), 32'd0);

        // Allocate 0x1000 -> 0x2000; same-cycle lookup still sees the old (empty) entry.
        upd(32'h1000, 1'b1, 32'h2000, 1'b0, 32'h1004);
        look(32'h0000_1000, 1'b0, 32'h0000_1004, "no_bypass_alloc");
        tick();
        idle();
        look(32'h0000_1000, 1'b1, 32'h0000_2000, "alloc");
        chk("alloc_mispredict", 32'(mispredict), 32'd1);
        chk("alloc_mis", mispred_count, 32'd1);
        chk("alloc_br", br_count, 32'd1);
        tick();
        chk("mispredict_pulse_end", 32'(mispredict), 32'd0);

        // Two not-taken: 10 -> 01 -> 00.
        upd(32'h1000, 1'b0, 32'h0, 1'b1, 32'h2000);
        tick();
        upd(32'h1000, 1'b0, 32'h0, 1'b0, 32'h1004);
        tick();
        idle();
        look(32'h0000_1000, 1'b0, 32'h0000_1004, "nt_twice");
        chk("nt_twice_mispredict", 32'(mispredict), 32'd0);
        chk("nt_twice_mis", mispred_count, 32'd2);
        chk("nt_twice_br", br_count, 32'd3);

        // Five correctly predicted taken updates: 00 -> 01 -> 10 -> 11 -> 11 -> 11.
        for (int i = 0; i < 5; i++) begin
            upd(32'h1000, 1'b1, 32'h2000, 1'b1, 32'h2000);
            tick();
        end
        idle();
        look(32'h0000_1000, 1'b1, 32'h0000_2000, "taken_x5");
        chk("taken_x5_br", br_count, 32'd8);
        chk("taken_x5_mis", mispred_count, 32'd2);
        chk("correct_no_mispredict", 32'(mispredict), 32'd0);

        // From 11 one not-taken must still predict taken; a second must not.
        upd(32'h1000, 1'b0, 32'h0, 1'b1, 32'h2000);
        tick();
        idle();
        look(32'h0000_1000, 1'b1, 32'h0000_2000, "sat_hi_nt1");
        upd(32'h1000, 1'b0, 32'h0, 1'b1, 32'h2000);
        tick();
        idle();
        look(32'h0000_1000, 1'b0, 32'h0000_1004, "sat_hi_nt2");
        chk("sat_hi_mis", mispred_count, 32'd4);
        chk("sat_hi_br", br_count, 32'd10);

        // Aliasing at index 0: 0x1080 replaces 0x1000. Second update is a target mispredict.
        upd(32'h1000, 1'b1, 32'h2000, 1'b0, 32'h1004);
        tick();
        upd(32'h1080, 1'b1, 32'h5000, 1'b1, 32'h2000);
        tick();
        idle();
        chk("target_mispredict", 32'(mispredict), 32'd1);
        chk("alias_mis", mispred_count, 32'd6);
        look(32'h0000_1000, 1'b0, 32'h0000_1004, "alias_old");
        look(32'h0000_1080, 1'b1, 32'h0000_5000, "alias_new");

        // Miss, not taken: no table change.
        upd(32'h1100, 1'b0, 32'h0, 1'b0, 32'h1104);
        tick();
        idle();
        look(32'h0000_1080, 1'b1, 32'h0000_5000, "miss_nt_keep");
        chk("miss_nt_br", br_count, 32'd13);

        // Clear together with an allocating update: clear wins, stats still move.
        upd(32'h3000, 1'b1, 32'h7000, 1'b0, 32'h3004);
        clear = 1'b1;
        tick();
        idle();
        look(32'h0000_3000, 1'b0, 32'h0000_3004, "clear_upd");
        look(32'h0000_1080, 1'b0, 32'h0000_1084, "clear_other");
        chk("clear_br", br_count, 32'd14);
        chk("clear_mis", mispred_count, 32'd7);
        chk("clear_mispredict", 32'(mispredict), 32'd1);

        // Allocate 0x3000, then a not-taken update while looking it up in the same cycle.
        upd(32'h3000, 1'b1, 32'h7000, 1'b1, 32'h7000);
        tick();
        upd(32'h3000, 1'b0, 32'h0, 1'b1, 32'h7000);
        look(32'h0000_3000, 1'b1, 32'h0000_7000, "no_bypass_nt");
        tick();
        idle();
        look(32'h0000_3000, 1'b0, 32'h0000_3004, "after_nt");
        chk("after_nt_br", br_count, 32'd16);
        chk("after_nt_mis", mispred_count, 32'd8);

        // Statistics saturation.
        force dut.brCount = 32'hFFFF_FFFF;
        force dut.mispredCount = 32'hFFFF_FFFF;
        #1;
        release dut.brCount;
        release dut.mispredCount;
        upd(32'h4000, 1'b1, 32'h4400, 1'b0, 32'h4004);
        tick();
        idle();
        chk("br_sat", br_count, 32'hFFFF_FFFF);
        chk("mis_sat", mispred_count, 32'hFFFF_FFFF);

        look(32'hFFFF_FFFC, 1'b0, 32'h0000_0000, "wrap");

        // Asynchronous reset in the middle of an update cycle.
        upd(32'h1080, 1'b1, 32'h5000, 1'b0, 32'h1084);
        #2 rst_n = 1'b0;
        #1;
        chk("async_br", br_count, 32'd0);
        chk("async_mis", mispred_count, 32'd0);
        chk("async_mispredict", 32'(mispredict), 32'd0);
        look(32'h0000_4000, 1'b0, 32'h0000_4004, "async_look");
        tick();
        idle();
        rst_n = 1'b1;
        tick();
        look(32'h0000_1080, 1'b0, 32'h0000_1084, "async_discard");
        chk("async_br_hold", br_count, 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, required finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
